// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor I/O hub: error-bit layout and the
// sticky-error update rule.
package proc_io_pkg;

  localparam int ERR_W        = 3;
  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_BAD_IN   = 1;
  localparam int ERR_BAD_OUT  = 2;

  typedef logic [ERR_W-1:0] err_t;

  // A clear wipes the old bits, but any bit being set on the same edge survives.
  function automatic err_t err_next(input err_t cur, input err_t set, input logic clr);
    return (clr ? '0 : cur) | set;
  endfunction

endpackage

// File: rtl/io_in_slot.sv
// One-entry input buffer: a data register plus a full flag. It can accept a
// new word when empty, or when the processor drains it on the same edge.
module io_in_slot #(
  parameter int NUBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rd,
  output logic [NUBITS-1:0] data,
  output logic              full
);

  logic load;

  assign in_ready = !full | rd;
  assign load     = in_valid & in_ready;

  // Load wins over consume, so a simultaneous read and write keeps the slot full.
  // NOTE: the data register is reset as well, so a reset never leaks a stale word onto proc_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      data <= in_data;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_io_hub.sv
// Processor I/O hub: NIN buffered input channels read by the processor and
// NOUT held output registers written by it, with sticky error reporting.
module proc_io_hub
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NBIOIN = 1,
  parameter int NBIOOU = 3,
  parameter int NIN    = 2,
  parameter int NOUT   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [NUBITS-1:0]      proc_in,
  input  logic [NBIOIN-1:0]      proc_addr_in,
  input  logic                   proc_req_in,
  input  logic [NUBITS-1:0]      proc_out,
  input  logic [NBIOOU-1:0]      proc_addr_out,
  input  logic                   proc_out_en,
  input  logic [NIN*NUBITS-1:0]  ext_in_data,
  input  logic [NIN-1:0]         ext_in_valid,
  output logic [NIN-1:0]         ext_in_ready,
  output logic [NOUT*NUBITS-1:0] ext_out_data,
  output logic [NOUT-1:0]        ext_out_valid,
  input  logic                   err_clr,
  output logic [ERR_W-1:0]       err
);

  logic [NIN-1:0]    in_hit;
  logic [NIN-1:0]    rd_hit;
  logic [NIN-1:0]    full;
  logic [NUBITS-1:0] slot_data [NIN];
  logic [NOUT-1:0]   out_hit;
  logic [NOUT-1:0]   wr_hit;
  err_t              err_set;

  // Input slots, one per channel; addresses with no matching slot select nothing.
  for (genvar i = 0; i < NIN; i++) begin : g_slot
    assign in_hit[i] = (proc_addr_in == NBIOIN'(i));
    assign rd_hit[i] = proc_req_in & in_hit[i];

    io_in_slot #(.NUBITS(NUBITS)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .in_data  (ext_in_data[i*NUBITS +: NUBITS]),
      .in_valid (ext_in_valid[i]),
      .in_ready (ext_in_ready[i]),
      .rd       (rd_hit[i]),
      .data     (slot_data[i]),
      .full     (full[i])
    );
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_out_hit
    assign out_hit[k] = (proc_addr_out == NBIOOU'(k));
  end
  assign wr_hit = out_hit & {NOUT{proc_out_en}};

  // Read mux: an unmapped input address returns zero.
  always_comb begin
    // NOTE: default first so no path through the loop leaves proc_in unassigned (no latch).
    proc_in = '0;
    for (int i = 0; i < NIN; i++) begin
      if (in_hit[i]) proc_in = slot_data[i];
    end
  end

  // Error sources for this edge.
  always_comb begin
    err_set               = '0;
    err_set[ERR_UNDERRUN] = |(rd_hit & ~full);
    err_set[ERR_BAD_IN]   = proc_req_in & ~|in_hit;
    err_set[ERR_BAD_OUT]  = proc_out_en & ~|out_hit;
  end

  // Output registers hold between writes; valid pulses for the cycle after each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_out_data  <= '0;
      ext_out_valid <= '0;
    end else begin
      ext_out_valid <= wr_hit;
      for (int k = 0; k < NOUT; k++) begin
        if (wr_hit[k]) ext_out_data[k*NUBITS +: NUBITS] <= proc_out;
      end
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= '0;
    else     err <= err_next(err, err_set, err_clr);
  end

endmodule

// File: doc/proc_io_hub.md
PROC_IO_HUB -- requirements
Module: proc_io_hub

Interface
REQ-001 SHALL have parameter NUBITS, default 32, processor data word width.
REQ-002 SHALL have parameter NBIOIN, default 1, processor input-address width.
REQ-003 SHALL have parameter NBIOOU, default 3, processor output-address width.
REQ-004 SHALL have parameter NIN, default 2, input channel count, 1 <= NIN <= 2**NBIOIN.
REQ-005 SHALL have parameter NOUT, default 7, output channel count, 1 <= NOUT <= 2**NBIOOU.
REQ-006 SHALL have ports, one per line:
 clk  in  1  single clock, all state on rising edge.
 rst  in  1  asynchronous, active-high reset.
 proc_in  out  NUBITS  word returned to processor.
 proc_addr_in  in  NBIOIN  input channel select.
 proc_req_in  in  1  processor read strobe.
 proc_out  in  NUBITS  word written by processor.
 proc_addr_out  in  NBIOOU  output channel select.
 proc_out_en  in  1  processor write strobe.
 ext_in_data  in  NIN*NUBITS  channel i at bits [i*NUBITS +: NUBITS].
 ext_in_valid  in  NIN  per-channel producer valid.
 ext_in_ready  out  NIN  per-channel slot can accept.
 ext_out_data  out  NOUT*NUBITS  per-channel held output word.
 ext_out_valid  out  NOUT  per-channel one-cycle update pulse.
 err_clr  in  1  synchronous clear of sticky errors.
 err  out  3  sticky: [0] underrun, [1] bad in-addr, [2] bad out-addr.

Function
REQ-007 Each input channel SHALL own a one-entry slot: data register plus full flag.
REQ-008 ext_in_ready[i] SHALL equal !full[i] | (proc_req_in & proc_addr_in==i), combinational.
REQ-009 Slot i SHALL load ext_in_data word i and set full on an edge with ext_in_valid[i] & ext_in_ready[i].
REQ-010 proc_in SHALL be combinational: data register of slot proc_addr_in; all zeros if proc_addr_in >= NIN.
REQ-011 On an edge with proc_req_in & proc_addr_in==i & full[i], the read SHALL consume the slot (full cleared) unless a load occurs the same edge, in which case full SHALL stay 1 with the new word.
REQ-012 proc_req_in to an empty slot SHALL return the stale data register, leave full at 0, and set err[0].
REQ-013 proc_req_in with proc_addr_in >= NIN SHALL set err[1] and change no slot.
REQ-014 On an edge with proc_out_en & proc_addr_out==k < NOUT, output register k SHALL load proc_out and ext_out_valid[k] SHALL be 1 for exactly the following cycle (latency 1).
REQ-015 Output registers SHALL hold their value between writes; consecutive writes to one channel SHALL give back-to-back valid pulses, each carrying its own word.
REQ-016 proc_out_en with proc_addr_out >= NOUT SHALL set err[2] and change no output.
REQ-017 err bits SHALL be sticky; err_clr SHALL clear them; a set and err_clr on the same edge SHALL leave the bit set.
REQ-018 Reads and writes in the same cycle SHALL be independent and both take effect.

Reset
REQ-019 rst SHALL asynchronously clear all slot data and full flags, all output registers, ext_out_valid and err to 0.
REQ-020 After rst deasserts, ext_in_ready SHALL be all ones; reset mid-transfer SHALL discard buffered words without a valid pulse.

Structure
REQ-021 Error-bit indices (ERR_UNDERRUN=0, ERR_BAD_IN=1, ERR_BAD_OUT=2) SHALL live in shared package proc_io_pkg.
REQ-022 The one-entry slot SHALL be sub-module io_in_slot, instantiated NIN times via generate; output logic stays in the top.

Verification
REQ-023 Write 0x3F800000 on ext channel 1, then proc_req_in addr 1 -> proc_in=0x3F800000, full[1] clears, ext_in_ready[1]=1 next cycle.
REQ-024 Slot 0 full with 5; same edge ext_in_valid[0]=1 with 9 and proc_req_in addr 0 -> proc_in=5 that cycle, slot holds 9, full stays 1.
REQ-025 proc_req_in addr 0 with slot empty -> err=3'b001, proc_in=stale value; err_clr next cycle -> err=0.
REQ-026 proc_out_en addr 6 data 0x12345678, then addr 2 data 7 next cycle -> ext_out_valid=7'b1000000 then 7'b0000100, words held.
REQ-027 proc_out_en addr 7 (NOUT=7) -> err[2]=1, no ext_out_valid pulse, all outputs unchanged.
REQ-028 Assert rst asynchronously mid-cycle with slots full -> full, outputs, err zero immediately; ext_in_ready all ones after release.
